axi_stream_packer: RTL and testbench
====================================

# axi_stream_packer

Width up-sizer that sits directly downstream of the valid/ready increment stage. It accepts DWIDTH-bit beats over a valid/ready handshake and packs RATIO consecutive beats into one DWIDTH*RATIO-bit output word. The output is a registered valid/ready port. Throughput is full: one input beat per cycle with no bubbles while the consumer is ready.

## Interface
- DWIDTH, 8, input beat width in bits.
- RATIO, 4, beats per output word; legal range 2..16.
- aclk_i  in  1  single clock; all logic on its rising edge.
- areset_i  in  1  reset; synchronous, active-high.
- valid_i  in  1  upstream beat valid.
- ready_o  out  1  upstream ready; combinational, see Operation.
- data_i  in  DWIDTH  upstream beat.
- valid_o  out  1  packed word valid; registered.
- ready_i  in  1  downstream ready.
- data_o  out  DWIDTH*RATIO  packed word; registered.
- keep_o  out  RATIO  per-lane valid mask; registered.
- flush_i  in  1  partial-word flush request; present only with AXI_PACK_FLUSH_EN.

## Operation
- Handshake terms:
  - Accept (acc) = valid_i & ready_o.
  - Output handshake (oh) = valid_o & ready_i.
- Lane counter:
  - cnt has width clog2(RATIO).
  - acc writes data_i into accumulator lane cnt. Lane 0 is bits [DWIDTH-1:0] and holds the first beat, so the layout is little-endian.
- Completing beat (acc with cnt==RATIO-1):
  - Load data_o with {data_i, accumulator lanes RATIO-2..0}.
  - Set keep_o to all ones.
  - Set valid_o=1 and cnt=0.
- Otherwise acc sets cnt=cnt+1.
- Output register:
  - Free = ~valid_o | ready_i.
  - While valid_o & ~ready_i, data_o, keep_o and valid_o are held stable.
  - oh with no new load clears valid_o. data_o and keep_o then keep their last value.
- ready_o = (cnt != RATIO-1) | ~valid_o | ready_i.
  - Lanes 0..RATIO-2 always absorb.
  - Only the completing beat can stall.
- Simultaneous oh and load in the same cycle: new word replaces old, valid_o stays 1.
- Reset (areset_i=1 at an edge):
  - cnt=0, accumulator=0, valid_o=0, data_o=0, keep_o=0, flush pending=0.
  - ready_o=1 after reset.
  - A mid-fill partial word is discarded and not emitted.
- No arithmetic on data; beats pass through bit-exact.

## Timing
- Latency: completing beat accepted at edge k gives valid_o=1 from edge k to the next oh.
- Sustained rate with ready_i held high: one word every RATIO cycles, ready_o never low.
- ready_o depends combinationally on ready_i. There is no path from valid_i to ready_o.
- Backpressure: with cnt==RATIO-1 and output busy, ready_o=0. ready_o rises in the same cycle ready_i rises.

## Configuration
- Macro AXI_PACK_FLUSH_EN.
- Defined:
  - flush_i port exists. A flush request is flush_i, or a pending flag set by flush_i and cleared when the partial word issues.
  - With request, cnt+acc>0, no completing beat and the output register free: load data_o with the filled lanes (including a beat accepted this cycle). Unused lanes are zero. keep_o has ones for filled lanes only. Set valid_o=1 and cnt=0.
  - While a request is pending and the output is busy, ready_o=0.
  - flush coincident with a completing beat: the full word issues and the request is dropped.
  - flush with cnt==0 and no acc: no-op, request dropped.
- Undefined:
  - No flush_i port and no pending flag.
  - keep_o is all ones whenever valid_o=1.

## Test plan
- DWIDTH=8, RATIO=4, ready_i=1; feed 0x11,0x22,0x33,0x44 back-to-back. Required response: valid_o=1 for one cycle after the 4th accept, data_o=0x44332211, keep_o=4'hF.
- Stream 0x01..0x08 continuously with ready_i=1. Required response: words 0x04030201 then 0x08070605 four cycles apart, ready_o constantly 1.
- Hold ready_i=0 after the first word issues, then feed 4 more beats. Required response:
  - ready_o=0 on the 4th beat; data_o stays 0x44332211.
  - When ready_i rises, ready_o=1 that cycle and the next word 0x88776655 loads at that edge.
- After 2 beats (0xAA,0xBB), pulse areset_i for one cycle. Required response:
  - valid_o=0, data_o=0, keep_o=0 during and after reset.
  - The next 4 beats 0x01..0x04 yield 0x04030201 with no residue.
- With AXI_PACK_FLUSH_EN: feed 0xAA,0xBB, then flush_i=1. Required response:
  - data_o=0x0000BBAA, keep_o=4'b0011, cnt=0.
  - A following flush with cnt==0 produces no output.
  - flush_i during ready_i=0 with a word pending: the partial word issues only after the pending word's handshake.

Source files
------------

// File: rtl/axi_stream_packer_if.sv
// Handshake bundle for axi_stream_packer.
// The upstream beat port, the packed-word port and, when AXI_PACK_FLUSH_EN is
// defined, the flush request. The signal names are given from the packer's
// point of view. The "slave" modport is the packer. The "master" modport is
// whatever drives the packer from both sides.
interface axi_stream_packer_if #(
  parameter int DWIDTH = 8,
  parameter int RATIO  = 4
);
  logic                      valid_i;
  logic                      ready_o;
  logic [DWIDTH-1:0]         data_i;
  logic                      valid_o;
  logic                      ready_i;
  logic [DWIDTH*RATIO-1:0]   data_o;
  logic [RATIO-1:0]          keep_o;
`ifdef AXI_PACK_FLUSH_EN
  logic                      flush_i;

  modport slave (
    input  valid_i, data_i, ready_i, flush_i,
    output ready_o, valid_o, data_o, keep_o
  );

  modport master (
    output valid_i, data_i, ready_i, flush_i,
    input  ready_o, valid_o, data_o, keep_o
  );
`else
  modport slave (
    input  valid_i, data_i, ready_i,
    output ready_o, valid_o, data_o, keep_o
  );

  modport master (
    output valid_i, data_i, ready_i,
    input  ready_o, valid_o, data_o, keep_o
  );
`endif
endinterface

// File: rtl/axi_stream_packer.sv
// axi_stream_packer: packs RATIO consecutive DWIDTH-bit beats into one
// little-endian DWIDTH*RATIO-bit word. Lane 0 holds the first beat.
// The output port (valid/data/keep) is registered.
// Only the completing beat can be stalled by a busy output register.
// Optional feature macro AXI_PACK_FLUSH_EN: a flush_i request emits a partial
// word. Unused lanes are zero and keep_o marks the filled lanes.
module axi_stream_packer #(
  parameter int DWIDTH = 8,
  parameter int RATIO  = 4
) (
  input  logic                aclk_i,
  input  logic                areset_i,
  axi_stream_packer_if.slave  bus
);

  localparam int            CW   = (RATIO > 2) ? $clog2(RATIO) : 1;
  localparam int            WW   = DWIDTH * RATIO;
  localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

  // Lane RATIO-1 is never stored. The completing beat goes straight to the
  // output register.
  logic [DWIDTH*(RATIO-1)-1:0] r_acc;
  logic [CW-1:0]               r_cnt;
  logic                        r_valid;
  logic [WW-1:0]               r_data;
  logic [RATIO-1:0]            r_keep;

  logic                        w_free;
  logic                        w_last;
  logic                        w_ready;
  logic                        w_acc;
  logic                        w_complete;
  logic                        w_load;
  logic [WW-1:0]               w_load_data;
  logic [RATIO-1:0]            w_load_keep;

`ifdef AXI_PACK_FLUSH_EN
  logic                        r_pend;
  logic                        w_req;
  logic                        w_flush_load;
  logic                        w_pend_next;
  logic [WW-1:0]               w_part_data;
  logic [RATIO-1:0]            w_part_keep;
`endif

  // Handshake decode and selection of the word to load into the output register.
  always_comb begin
    w_free      = ~r_valid | bus.ready_i;
    w_last      = (r_cnt == LAST);
`ifdef AXI_PACK_FLUSH_EN
    w_req       = bus.flush_i | r_pend;
    // A request that is waiting for the output also blocks new beats. This
    // stops the partial word from growing while it waits for the output.
    w_ready     = (~w_last | w_free) & ~(w_req & ~w_free);
`else
    w_ready     = ~w_last | w_free;
`endif
    w_acc       = bus.valid_i & w_ready;
    w_complete  = w_acc & w_last;
    w_load      = w_complete;
    w_load_data = {bus.data_i, r_acc};
    w_load_keep = '1;
`ifdef AXI_PACK_FLUSH_EN
    w_part_data = '0;
    w_part_keep = '0;
    // Without a completing beat, a filled lane index is at most RATIO-2.
    // So the top lane of a partial word is always empty.
    for (int j = 0; j < RATIO - 1; j++) begin
      if (j < int'(r_cnt)) begin
        w_part_data[j*DWIDTH +: DWIDTH] = r_acc[j*DWIDTH +: DWIDTH];
        w_part_keep[j]                  = 1'b1;
      end else if (w_acc && (j == int'(r_cnt))) begin
        w_part_data[j*DWIDTH +: DWIDTH] = bus.data_i;
        w_part_keep[j]                  = 1'b1;
      end
    end
    w_flush_load = w_req & ((r_cnt != '0) | w_acc) & ~w_complete & w_free;
    // The request is dropped when it is served, when a full word overtakes it,
    // or when there is nothing to flush.
    w_pend_next  = w_req & ~(w_complete | w_flush_load |
                             ((r_cnt == '0) & ~w_acc));
    if (w_flush_load) begin
      w_load      = 1'b1;
      w_load_data = w_part_data;
      w_load_keep = w_part_keep;
    end
`endif
  end

  // Lane counter and accumulator: each accepted beat fills the next lane.
  // Any word load restarts the counter at lane 0.
  always_ff @(posedge aclk_i) begin
    if (areset_i) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else if (w_load) begin
      r_cnt <= '0;
    end else if (w_acc) begin
      r_cnt <= r_cnt + CW'(1);
      for (int j = 0; j < RATIO - 1; j++) begin
        if (r_cnt == CW'(j)) r_acc[j*DWIDTH +: DWIDTH] <= bus.data_i;
      end
    end
  end

  // Output register. A load wins over the handshake, so a back-to-back word
  // replaces the old one without a bubble.
  always_ff @(posedge aclk_i) begin
    if (areset_i) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_keep  <= '0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_data  <= w_load_data;
      r_keep  <= w_load_keep;
    end else if (r_valid && bus.ready_i) begin
      r_valid <= 1'b0;
    end
  end

`ifdef AXI_PACK_FLUSH_EN
  // Flush request that is held until the output register can take the partial word.
  always_ff @(posedge aclk_i) begin
    if (areset_i) r_pend <= 1'b0;
    else          r_pend <= w_pend_next;
  end
`endif

  assign bus.ready_o = w_ready;
  assign bus.valid_o = r_valid;
  assign bus.data_o  = r_data;
  assign bus.keep_o  = r_keep;

endmodule

// File: tb/tb_axi_stream_packer.sv
// Bench for axi_stream_packer with DWIDTH=8 and RATIO=4.
// It runs a table of per-cycle vectors, then a hand-written flush sequence
// when AXI_PACK_FLUSH_EN is defined. Last comes randomized traffic, checked
// against a queue-based packing model.
module tb_axi_stream_packer;
  localparam int DW = 8;
  localparam int R  = 4;

  logic aclk_i = 1'b0;
  logic areset_i;
  always #5 aclk_i = ~aclk_i;

  axi_stream_packer_if #(.DWIDTH(DW), .RATIO(R)) bus ();

  axi_stream_packer #(.DWIDTH(DW), .RATIO(R)) dut (
    .aclk_i   (aclk_i),
    .areset_i (areset_i),
    .bus      (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        r;
    logic        rst;
    logic        e_rdy;
    logic        e_val;
    logic [31:0] e_data;
    logic [3:0]  e_keep;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic v, logic [7:0] d, logic r, logic rst,
                              logic e_rdy, logic e_val, logic [31:0] e_data,
                              logic [3:0] e_keep);
    vec_t x;
    x.v = v; x.d = d; x.r = r; x.rst = rst;
    x.e_rdy = e_rdy; x.e_val = e_val; x.e_data = e_data; x.e_keep = e_keep;
    return x;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(logic v, logic [7:0] d, logic r, logic rst, logic fl);
    bus.valid_i = v;
    bus.data_i  = d;
    bus.ready_i = r;
    areset_i    = rst;
`ifdef AXI_PACK_FLUSH_EN
    bus.flush_i = fl;
`else
    if (fl) $display("note: flush ignored in this build");
`endif
  endtask

  // Inputs change 1 time unit after the rising edge. ready_o is sampled 2
  // units later, clear of both edges.
  task automatic step(logic v, logic [7:0] d, logic r, logic rst, logic fl,
                      output logic rdy);
    drive(v, d, r, rst, fl);
    #2;
    rdy = bus.ready_o;
    @(posedge aclk_i);
    #1;
  endtask

  logic        rdy;
  logic [7:0]  beats[$];
  logic [31:0] words[$];
  logic [31:0] exp_w;
  logic [31:0] prev_data;
  logic        prev_stall;
  logic        rv, rr, vo;
  logic [7:0]  rd;
  logic [31:0] dout;
  logic [3:0]  kout;

  // One random cycle. Words leaving the DUT are compared in order against
  // words built from the accepted beat stream.
  task automatic rand_cycle(logic v, logic [7:0] d, logic r);
    drive(v, d, r, 1'b0, 1'b0);
    #2;
    rdy  = bus.ready_o;
    vo   = bus.valid_o;
    dout = bus.data_o;
    kout = bus.keep_o;
    if (r) chk("rand_ready_with_ready_i", rdy, 1);
    if (prev_stall) begin
      chk("rand_stall_valid_held", vo, 1);
      chk("rand_stall_data_held", dout, prev_data);
    end
    if (vo && r) begin
      if (words.size() == 0) begin
        chk("rand_spurious_word", 1, 0);
      end else begin
        exp_w = words.pop_front();
        chk("rand_word_data", dout, exp_w);
        chk("rand_word_keep", kout, 4'hF);
      end
    end
    if (v && rdy) begin
      beats.push_back(d);
      if (beats.size() == R) begin
        exp_w = {beats[3], beats[2], beats[1], beats[0]};
        words.push_back(exp_w);
        beats.delete();
      end
    end
    prev_stall = vo & ~r;
    prev_data  = dout;
    @(posedge aclk_i);
    #1;
  endtask

  initial begin
    // Reset state.
    drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    repeat (2) @(posedge aclk_i);
    #1;
    chk("reset_valid", bus.valid_o, 0);
    chk("reset_data", bus.data_o, 0);
    chk("reset_keep", bus.keep_o, 0);
    chk("reset_ready", bus.ready_o, 1);

    //              v  d      r  rst  rdy val data          keep
    // Basic packing, then a continuous stream with the consumer ready.
    vt.push_back(mk(1, 8'h11, 1, 0,   1,  0,  32'h0,        4'h0));
    vt.push_back(mk(1, 8'h22, 1, 0,   1,  0,  32'h0,        4'h0));
    vt.push_back(mk(1, 8'h33, 1, 0,   1,  0,  32'h0,        4'h0));
    vt.push_back(mk(1, 8'h44, 1, 0,   1,  1,  32'h44332211, 4'hF));
    vt.push_back(mk(0, 8'h00, 1, 0,   1,  0,  32'h44332211, 4'hF));
    vt.push_back(mk(1, 8'h01, 1, 0,   1,  0,  32'h44332211, 4'hF));
    vt.push_back(mk(1, 8'h02, 1, 0,   1,  0,  32'h44332211, 4'hF));
    vt.push_back(mk(1, 8'h03, 1, 0,   1,  0,  32'h44332211, 4'hF));
    vt.push_back(mk(1, 8'h04, 1, 0,   1,  1,  32'h04030201, 4'hF));
    vt.push_back(mk(1, 8'h05, 1, 0,   1,  0,  32'h04030201, 4'hF));
    vt.push_back(mk(1, 8'h06, 1, 0,   1,  0,  32'h04030201, 4'hF));
    vt.push_back(mk(1, 8'h07, 1, 0,   1,  0,  32'h04030201, 4'hF));
    vt.push_back(mk(1, 8'h08, 1, 0,   1,  1,  32'h08070605, 4'hF));
    // Backpressure: reset, fill one word with ready_i low, then stall.
    vt.push_back(mk(0, 8'h00, 1, 1,   1,  0,  32'h0,        4'h0));
    vt.push_back(mk(1, 8'h11, 1, 0,   1,  0,  32'h0,        4'h0));
    vt.push_back(mk(1, 8'h22, 1, 0,   1,  0,  32'h0,        4'h0));
    vt.push_back(mk(1, 8'h33, 1, 0,   1,  0,  32'h0,        4'h0));
    vt.push_back(mk(1, 8'h44, 0, 0,   1,  1,  32'h44332211, 4'hF));
    vt.push_back(mk(1, 8'h55, 0, 0,   1,  1,  32'h44332211, 4'hF));
    vt.push_back(mk(1, 8'h66, 0, 0,   1,  1,  32'h44332211, 4'hF));
    vt.push_back(mk(1, 8'h77, 0, 0,   1,  1,  32'h44332211, 4'hF));
    vt.push_back(mk(1, 8'h88, 0, 0,   0,  1,  32'h44332211, 4'hF));
    vt.push_back(mk(1, 8'h88, 0, 0,   0,  1,  32'h44332211, 4'hF));
    vt.push_back(mk(1, 8'h88, 1, 0,   1,  1,  32'h88776655, 4'hF));
    vt.push_back(mk(0, 8'h00, 1, 0,   1,  0,  32'h88776655, 4'hF));
    // Mid-fill reset discards the partial word.
    vt.push_back(mk(1, 8'hAA, 1, 0,   1,  0,  32'h88776655, 4'hF));
    vt.push_back(mk(1, 8'hBB, 1, 0,   1,  0,  32'h88776655, 4'hF));
    vt.push_back(mk(0, 8'h00, 1, 1,   1,  0,  32'h0,        4'h0));
    vt.push_back(mk(1, 8'h01, 1, 0,   1,  0,  32'h0,        4'h0));
    vt.push_back(mk(1, 8'h02, 1, 0,   1,  0,  32'h0,        4'h0));
    vt.push_back(mk(1, 8'h03, 1, 0,   1,  0,  32'h0,        4'h0));
    vt.push_back(mk(1, 8'h04, 1, 0,   1,  1,  32'h04030201, 4'hF));
    vt.push_back(mk(0, 8'h00, 1, 0,   1,  0,  32'h04030201, 4'hF));

    foreach (vt[i]) begin
      step(vt[i].v, vt[i].d, vt[i].r, vt[i].rst, 1'b0, rdy);
      chk($sformatf("vec%0d_ready", i), rdy, vt[i].e_rdy);
      chk($sformatf("vec%0d_valid", i), bus.valid_o, vt[i].e_val);
      chk($sformatf("vec%0d_data", i), bus.data_o, vt[i].e_data);
      chk($sformatf("vec%0d_keep", i), bus.keep_o, vt[i].e_keep);
    end

`ifdef AXI_PACK_FLUSH_EN
    // Partial flush of two beats.
    step(1, 8'hAA, 1, 0, 0, rdy);
    step(1, 8'hBB, 1, 0, 0, rdy);
    step(0, 8'h00, 1, 0, 1, rdy);
    chk("flush_valid", bus.valid_o, 1);
    chk("flush_data", bus.data_o, 32'h0000BBAA);
    chk("flush_keep", bus.keep_o, 4'b0011);
    // Flush with nothing accumulated: no word.
    step(0, 8'h00, 1, 0, 1, rdy);
    chk("flush_empty_valid", bus.valid_o, 0);
    step(0, 8'h00, 1, 0, 0, rdy);
    chk("flush_empty_no_late_word", bus.valid_o, 0);
    // Flush while a full word waits on the consumer.
    step(1, 8'h11, 0, 0, 0, rdy);
    step(1, 8'h22, 0, 0, 0, rdy);
    step(1, 8'h33, 0, 0, 0, rdy);
    step(1, 8'h44, 0, 0, 0, rdy);
    chk("flush_busy_word", bus.data_o, 32'h44332211);
    step(1, 8'h5A, 0, 0, 0, rdy);
    step(0, 8'h00, 0, 0, 1, rdy);
    chk("flush_busy_ready_low", rdy, 0);
    chk("flush_busy_data_held", bus.data_o, 32'h44332211);
    step(0, 8'h00, 0, 0, 0, rdy);
    chk("flush_pending_ready_low", rdy, 0);
    chk("flush_pending_data_held", bus.data_o, 32'h44332211);
    step(0, 8'h00, 1, 0, 0, rdy);
    chk("flush_pending_ready_rises", rdy, 1);
    chk("flush_pending_valid", bus.valid_o, 1);
    chk("flush_pending_data", bus.data_o, 32'h0000005A);
    chk("flush_pending_keep", bus.keep_o, 4'b0001);
    step(0, 8'h00, 1, 0, 0, rdy);
    chk("flush_pending_done", bus.valid_o, 0);
`endif

    // Randomized traffic against the packing model.
    step(0, 8'h00, 1, 1, 0, rdy);
    beats.delete();
    words.delete();
    prev_stall = 1'b0;
    prev_data  = '0;
    for (int n = 0; n < 3000; n++) begin
      rv = ($urandom_range(0, 3) != 0);
      rd = 8'($urandom);
      rr = ($urandom_range(0, 2) != 0);
      rand_cycle(rv, rd, rr);
    end
    for (int n = 0; n < 8; n++) rand_cycle(1'b0, 8'h00, 1'b1);
    chk("rand_drain_words_left", words.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
